// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: control/branch inputs from decode and the lookup table,
// plus the program counter and status returned toward memory and the bench.
interface instr_fetch_if #(
    parameter int PW = 16
);
    logic          Start;
    logic [PW-1:0] StartAddr;
    logic          Stall;
    logic          BranchAbs;
    logic          BranchRel;
    logic          Taken;
    logic [PW-1:0] Target;
    logic          Halt;
    logic [PW-1:0] ProgCtr;
    logic          Running;
    logic          Done;
    logic [15:0]   InstCount;

    modport slave (
        input  Start, StartAddr, Stall, BranchAbs, BranchRel, Taken, Target, Halt,
        output ProgCtr, Running, Done, InstCount
    );

    modport master (
        output Start, StartAddr, Stall, BranchAbs, BranchRel, Taken, Target, Halt,
        input  ProgCtr, Running, Done, InstCount
    );
endinterface

// File: rtl/instr_fetch.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE control, zero-latency
// branch application and a saturating retired-instruction counter.
module instr_fetch #(
    parameter int            PW       = 16,
    parameter logic [PW-1:0] RESET_PC = '0
) (
    input  logic         Clk,
    input  logic         Reset_n,
    instr_fetch_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          running_q, done_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                pc_d = RESET_PC;
                if (bus.Start) begin
                    pc_d    = bus.StartAddr;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.Start) begin
                    pc_d  = bus.StartAddr;
                    cnt_d = '0;
                end else if (bus.Halt) begin
                    state_d = DONE;
                    cnt_d   = sat_inc(cnt_q);
                end else if (!bus.Stall) begin
                    // Absolute outranks relative when decode raises both.
                    if (bus.BranchAbs && bus.Taken)
                        pc_d = bus.Target;
                    else if (bus.BranchRel && bus.Taken)
                        pc_d = pc_q + bus.Target;
                    else
                        pc_d = pc_q + 1'b1;
                    cnt_d = sat_inc(cnt_q);
                end
            end
            DONE: begin
                if (bus.Start) begin
                    pc_d    = bus.StartAddr;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
        end
    end

    assign bus.ProgCtr   = pc_q;
    assign bus.Running   = running_q;
    assign bus.Done      = done_q;
    assign bus.InstCount = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with hand-computed PC/count expectations.
module tb_instr_fetch;

    logic Clk;
    logic Reset_n;
    int   n_pass;
    int   n_total;

    instr_fetch_if #(.PW(16)) bus ();

    instr_fetch #(.PW(16), .RESET_PC(16'h0000)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        bus.Start     = 1'b0;
        bus.StartAddr = 16'h0000;
        bus.Stall     = 1'b0;
        bus.BranchAbs = 1'b0;
        bus.BranchRel = 1'b0;
        bus.Taken     = 1'b0;
        bus.Target    = 16'h0000;
        bus.Halt      = 1'b0;
    endtask

    task automatic start_at(input logic [15:0] a);
        clr();
        bus.Start     = 1'b1;
        bus.StartAddr = a;
        step();
        clr();
    endtask

    task automatic jump_abs(input logic [15:0] t);
        clr();
        bus.BranchAbs = 1'b1;
        bus.Taken     = 1'b1;
        bus.Target    = t;
        step();
        clr();
    endtask

    task automatic chk_state(input string tag, input logic [15:0] pc, input logic run,
                             input logic done, input logic [15:0] cnt);
        check({tag, ".pc"},   bus.ProgCtr,   pc);
        check({tag, ".run"},  bus.Running,   run);
        check({tag, ".done"}, bus.Done,      done);
        check({tag, ".cnt"},  bus.InstCount, cnt);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        clr();
        Reset_n = 1'b0;
        step();
        step();
        chk_state("reset", 16'h0000, 1'b0, 1'b0, 16'h0000);
        Reset_n = 1'b1;

        // IDLE ignores everything but Start
        bus.Stall = 1'b1; bus.Halt = 1'b1; bus.BranchAbs = 1'b1;
        bus.Taken = 1'b1; bus.Target = 16'h0055;
        step();
        chk_state("idle_ignore", 16'h0000, 1'b0, 1'b0, 16'h0000);

        start_at(16'h0010);
        chk_state("start", 16'h0010, 1'b1, 1'b0, 16'h0000);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("seq%0d.pc", i), bus.ProgCtr, 16'h0010 + i);
        end
        check("seq.cnt", bus.InstCount, 16'd4);

        jump_abs(16'h0020);
        check("abs20.pc", bus.ProgCtr, 16'h0020);
        bus.BranchRel = 1'b1; bus.Taken = 1'b1; bus.Target = 16'hFFFF;
        step();
        clr();
        check("rel_m1.pc", bus.ProgCtr, 16'h001F);
        check("rel_m1.cnt", bus.InstCount, 16'd6);

        jump_abs(16'h0020);
        bus.BranchRel = 1'b1; bus.Taken = 1'b0; bus.Target = 16'hFFFF;
        step();
        clr();
        check("rel_nt.pc", bus.ProgCtr, 16'h0021);

        jump_abs(16'h0005);
        bus.BranchAbs = 1'b1; bus.BranchRel = 1'b1; bus.Taken = 1'b1; bus.Target = 16'h0F03;
        step();
        clr();
        check("both.pc", bus.ProgCtr, 16'h0F03);
        check("both.cnt", bus.InstCount, 16'd10);

        jump_abs(16'hFFFF);
        step();
        chk_state("wrap", 16'h0000, 1'b1, 1'b0, 16'd12);

        jump_abs(16'h0030);
        bus.Stall = 1'b1; bus.BranchAbs = 1'b1; bus.Taken = 1'b1; bus.Target = 16'h0099;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("stall%0d.pc", i), bus.ProgCtr, 16'h0030);
            check($sformatf("stall%0d.cnt", i), bus.InstCount, 16'd13);
        end
        clr();
        bus.Halt = 1'b1; bus.Stall = 1'b1;
        step();
        clr();
        chk_state("halt", 16'h0030, 1'b0, 1'b1, 16'd14);

        // DONE ignores branches, stall and halt
        bus.BranchAbs = 1'b1; bus.Taken = 1'b1; bus.Target = 16'h0077; bus.Halt = 1'b1;
        step();
        clr();
        chk_state("done_hold", 16'h0030, 1'b0, 1'b1, 16'd14);

        start_at(16'h0003);
        chk_state("restart", 16'h0003, 1'b1, 1'b0, 16'h0000);

        step();
        bus.Start = 1'b1; bus.StartAddr = 16'h0040; bus.Halt = 1'b1;
        step();
        clr();
        chk_state("start_over_halt", 16'h0040, 1'b1, 1'b0, 16'h0000);

        // Asynchronous reset mid-cycle, checked before the next edge
        step();
        #2;
        Reset_n = 1'b0;
        #1;
        chk_state("async_rst", 16'h0000, 1'b0, 1'b0, 16'h0000);
        #1;
        Reset_n = 1'b1;
        step();
        chk_state("post_rst", 16'h0000, 1'b0, 1'b0, 16'h0000);

        start_at(16'h0000);
        for (int i = 0; i < 65540; i++) step();
        check("sat.cnt", bus.InstCount, 16'hFFFF);
        check("sat.run", bus.Running, 1'b1);
        step();
        check("sat_hold.cnt", bus.InstCount, 16'hFFFF);
        start_at(16'h0100);
        chk_state("sat_clear", 16'h0100, 1'b1, 1'b0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Program-counter and fetch-sequencing stage of the basic processor. It holds the architectural program counter, advances it each cycle, and applies branch targets produced by the branch-target lookup table. The current instruction's decoded branch controls and the table's 16-bit `Target` are sampled at the same clock edge. It drives `ProgCtr` into instruction memory and reports run/done status and a retired-instruction count to the testbench.

## Interface
- `PW`, 16, program-counter width; equals the `Target` width.
- `RESET_PC`, 16'h0000, value of `ProgCtr` while idle and after reset.

- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  one-cycle request to begin execution at `StartAddr`.
- `StartAddr`  in  PW  program entry address, sampled with `Start`.
- `Stall`  in  1  holds the PC and suppresses counting for this cycle.
- `BranchAbs`  in  1  current instruction is an absolute branch.
- `BranchRel`  in  1  current instruction is a PC-relative branch.
- `Taken`  in  1  branch condition flag from the ALU.
- `Target`  in  PW  branch target or offset from the lookup table; combinational for the current instruction.
- `Halt`  in  1  current instruction is the halt instruction.
- `ProgCtr`  out  PW  current instruction address (registered).
- `Running`  out  1  high in the RUN state.
- `Done`  out  1  high in the DONE state.
- `InstCount`  out  16  count of retired instructions; saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, RUN, DONE. Reset forces IDLE.
  - IDLE: `ProgCtr`=`RESET_PC`, `Running`=0, `Done`=0.
  - RUN: `Running`=1.
  - DONE: `Done`=1; `ProgCtr` holds the halt instruction's address.
- IDLE, `Start`=1: `ProgCtr`<=`StartAddr`, `InstCount`<=0, next state RUN. All other inputs are ignored in IDLE.
- RUN, per-cycle priority (highest first):
  1. `Start`: restart exactly as from IDLE.
  2. `Halt`: next state DONE, PC holds, `InstCount` += 1.
  3. `Stall`: PC and `InstCount` hold.
  4. `BranchAbs` & `Taken`: PC <= `Target`.
  5. `BranchRel` & `Taken`: PC <= PC + `Target`.
  6. Otherwise: PC <= PC + 1.
- Cases 4–6 increment `InstCount` by 1.
- `BranchAbs` and `BranchRel` both high: absolute wins.
- A branch with `Taken`=0 falls through to PC+1.
- Relative arithmetic: `Target` is a two's-complement offset, summed modulo 2^PW with no overflow flag. Examples: `Target`=16'hFFFF gives PC-1; PC 16'hFFFF + 1 wraps to 16'h0000.
- DONE: all inputs except `Start` are ignored. `Start` restarts as from IDLE.
- `InstCount` saturates: once at 16'hFFFF it stays there until the next `Start` or reset.

## Timing
- All outputs are registered. Reset values: `ProgCtr`=`RESET_PC`, `Running`=0, `Done`=0, `InstCount`=0.
- Reset assertion takes effect immediately, asynchronously, in any state, including mid-branch. Release is sampled at the next rising edge.
- `Start` sampled at edge N: `ProgCtr`=`StartAddr` and `Running`=1 after edge N.
- Branch decision latency is zero: controls and `Target` present before edge N set `ProgCtr` after edge N. There is no delay slot.
- `Halt` sampled at edge N: `Done`=1 and `Running`=0 after edge N.
- `Stall` is level-sensitive and may be held for any number of cycles with no loss of state.

## Test plan
- Reset then `Start`, `StartAddr`=16'h0010, no branches for 4 cycles -> `ProgCtr` sequence 10,11,12,13,14; `InstCount`=4.
- At PC 16'h0020: `BranchRel`=1, `Taken`=1, `Target`=16'hFFFF -> PC 16'h001F. Same with `Taken`=0 -> PC 16'h0021.
- At PC 16'h0005: `BranchAbs`=1, `BranchRel`=1, `Taken`=1, `Target`=16'h0F03 -> PC 16'h0F03. At PC 16'hFFFF with plain increment -> PC 16'h0000.
- `Stall` held for 3 cycles at PC 16'h0030 -> PC and `InstCount` unchanged. Then `Halt` with `Stall`=1 -> DONE, PC 16'h0030, `Done`=1 next cycle.
- In DONE, pulse `Start` with `StartAddr`=16'h0003 -> RUN, PC 16'h0003, `InstCount`=0. Asserting `Reset_n`=0 mid-cycle -> outputs go to reset values before the next edge.
- Run 65,540 non-stalled cycles -> `InstCount` holds at 16'hFFFF.
